// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package program_loader_pkg;

   // Last valid instruction memory address (existing data_size value).
   localparam logic [15:0] DATA_SIZE = 16'd1023;

   typedef enum logic [2:0] {
      LDR_IDLE    = 3'd0,
      LDR_LEN_HI  = 3'd1,
      LDR_LEN_LO  = 3'd2,
      LDR_DATA_HI = 3'd3,
      LDR_DATA_LO = 3'd4,
      LDR_WRITE   = 3'd5,
      LDR_DONE    = 3'd6,
      LDR_ERROR   = 3'd7
   } ldr_state_t;

   // States in which the loader takes a byte from the stream.
   function automatic logic ldr_accepts(input ldr_state_t s);
      return (s == LDR_LEN_HI) || (s == LDR_LEN_LO) ||
             (s == LDR_DATA_HI) || (s == LDR_DATA_LO);
   endfunction

   // States in which the CPU must be held in reset.
   function automatic logic ldr_busy(input ldr_state_t s);
      return ldr_accepts(s) || (s == LDR_WRITE);
   endfunction

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: LEN_HI, LEN_LO, then LEN big-endian 16-bit
// words written to consecutive instruction memory addresses from 0.
// Every output is registered from the next state so it lines up with it.
module program_loader
   import program_loader_pkg::*;
#(
   parameter logic [15:0] MEM_LAST = DATA_SIZE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        instruction_write,
   output logic [15:0] load_address,
   output logic [15:0] instruction_in,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_error
);

   // Max program length in 17 bits so MEM_LAST = 16'hFFFF cannot wrap.
   localparam logic [16:0] MAX_LEN = {1'b0, MEM_LAST} + 17'd1;

   ldr_state_t  state, state_nxt;
   logic [15:0] len;
   logic [15:0] count;
   logic [15:0] len_full;
   logic [15:0] count_inc;
   logic        xfer;
   logic        last_word;

   assign xfer      = rx_valid & rx_ready;
   assign len_full  = {len[15:8], rx_data};
   assign count_inc = count + 16'd1;
   assign last_word = (count_inc == len);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LDR_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; load_start only matters between sessions.
   always_comb begin
      state_nxt = state;
      case (state)
         LDR_IDLE, LDR_DONE, LDR_ERROR:
            if (load_start) state_nxt = LDR_LEN_HI;
         LDR_LEN_HI:
            if (xfer) state_nxt = LDR_LEN_LO;
         LDR_LEN_LO:
            if (xfer) begin
               if (len_full == 16'd0)                 state_nxt = LDR_DONE;
               else if ({1'b0, len_full} > MAX_LEN)   state_nxt = LDR_ERROR;
               else                                   state_nxt = LDR_DATA_HI;
            end
         LDR_DATA_HI:
            if (xfer) state_nxt = LDR_DATA_LO;
         LDR_DATA_LO:
            if (xfer) state_nxt = LDR_WRITE;
         LDR_WRITE:
            state_nxt = last_word ? LDR_DONE : LDR_DATA_HI;
         default:
            state_nxt = LDR_IDLE;
      endcase
   end

   // Registered status/strobe outputs derived from the upcoming state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ready          <= 1'b0;
         instruction_write <= 1'b0;
         cpu_hold          <= 1'b0;
         load_done         <= 1'b0;
         load_error        <= 1'b0;
      end else begin
         rx_ready          <= ldr_accepts(state_nxt);
         instruction_write <= (state_nxt == LDR_WRITE);
         cpu_hold          <= ldr_busy(state_nxt);
         load_done         <= (state_nxt == LDR_DONE);
         load_error        <= (state_nxt == LDR_ERROR);
      end
   end

   // Length, word assembly and address/count bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len            <= '0;
         count          <= '0;
         load_address   <= '0;
         instruction_in <= '0;
      end else begin
         case (state)
            LDR_IDLE, LDR_DONE, LDR_ERROR:
               if (load_start) begin
                  load_address <= '0;
                  count        <= '0;
               end
            LDR_LEN_HI:  if (xfer) len[15:8]            <= rx_data;
            LDR_LEN_LO:  if (xfer) len[7:0]             <= rx_data;
            LDR_DATA_HI: if (xfer) instruction_in[15:8] <= rx_data;
            LDR_DATA_LO: if (xfer) instruction_in[7:0]  <= rx_data;
            LDR_WRITE:
               // Address only advances when another word follows, so it
               // never passes MEM_LAST.
               if (!last_word) begin
                  load_address <= load_address + 16'd1;
                  count        <= count_inc;
               end
            default: ;
         endcase
      end
   end

endmodule
